sliding_window_buffer: RTL and testbench
========================================

SLIDING_WINDOW_BUFFER -- requirements
Module: sliding_window_buffer

Interface
REQ-001 SHALL have parameter SIZE_ROW, default 352: pixels per image row, a multiple of PIX_PER_WORD.
REQ-002 SHALL have parameter PIX_PER_WORD, default 4: pixels packed per input word.
REQ-003 SHALL have parameter PIX_W, default 8: bits per pixel.
REQ-004 SHALL have parameter NUM_LINES, default 3, legal range >=2: window height in rows.
REQ-005 SHALL have parameter BORDER_MODE, default 0: 0 = zero-pad columns -1 and SIZE_ROW; 1 = replicate the edge pixel.
REQ-006 SHALL use derived constants WORDS = SIZE_ROW/PIX_PER_WORD, WIN_W = PIX_PER_WORD+2, CW = $clog2(WORDS).
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 i_valid  in  1  i_word carries a pixel word.
REQ-010 i_ready  out  1  block accepts i_word this cycle; a transfer occurs when i_valid && i_ready.
REQ-011 i_sof  in  1  qualifies i_word as the first word of a frame (row 0, column 0).
REQ-012 i_word  in  PIX_PER_WORD*PIX_W  pixels; pixel k in bits [k*PIX_W +: PIX_W], lowest column first.
REQ-013 o_valid  out  1  o_window is valid.
REQ-014 o_ready  in  1  downstream consumes; a transfer occurs when o_valid && o_ready.
REQ-015 o_window  out  NUM_LINES*WIN_W*PIX_W  window; element (r,c) at index r*WIN_W+c; r=0 oldest row; c=0 is column sc*PIX_PER_WORD-1.
REQ-016 o_col  out  CW  scan word index sc of the current window.
REQ-017 o_last  out  1  high with o_valid when sc = WORDS-1.
REQ-018 o_row  out  16  count of window rows completed since the last i_sof, wrapping modulo 2^16.

Function
REQ-019 SHALL hold NUM_LINES row registers L[0..NUM_LINES-1] of SIZE_ROW pixels, plus a staging row S, column counter wc (CW bits) and rows_loaded counter, which saturates at NUM_LINES.
REQ-020 SHALL implement FSM states ACCEPT (i_ready=1, o_valid=0) and SCAN (i_ready=0, o_valid=1).
REQ-021 In ACCEPT, each input transfer SHALL write i_word into S at word column wc and increment wc.
REQ-022 An input transfer with i_sof=1 SHALL clear rows_loaded and o_row, and SHALL write the word at column 0 regardless of wc; wc then becomes 1.
REQ-023 On an input transfer at wc = WORDS-1, the same edge SHALL perform: L[k] <= L[k+1] for k < NUM_LINES-1; L[NUM_LINES-1] <= S including the final word; wc <= 0; rows_loaded incremented with saturation.
REQ-024 After that edge, the FSM SHALL go to SCAN if the updated rows_loaded = NUM_LINES, else remain in ACCEPT.
REQ-025 The first o_valid of a row SHALL appear the cycle after the last-word transfer (latency 1), with sc = 0.
REQ-026 In SCAN, o_window SHALL be a combinational function of L[] and sc; o_window, o_col and o_last SHALL be held stable while o_valid && !o_ready.
REQ-027 Each output transfer SHALL increment sc; a transfer with o_last=1 SHALL reset sc to 0, increment o_row, and return the FSM to ACCEPT on the next edge.
REQ-028 Column -1 (sc=0) and column SIZE_ROW (sc=WORDS-1) SHALL be 0 when BORDER_MODE=0, and L[r][0] or L[r][SIZE_ROW-1] respectively when BORDER_MODE=1.
REQ-029 No vertical padding SHALL be applied; a frame of H rows SHALL yield H-NUM_LINES+1 window rows.
REQ-030 i_sof asserted while i_valid=0 or while i_ready=0 SHALL have no effect.
REQ-031 An i_sof transfer mid-row SHALL discard the partial row in S; L[] is not cleared.

Reset
REQ-032 While reset is high, i_ready and o_valid SHALL be 0.
REQ-033 Reset SHALL set: state ACCEPT; wc, sc, rows_loaded and o_row to 0; all L[] and S pixels to 0.
REQ-034 Reset asserted during SCAN or mid-row SHALL abandon the row; the first cycle after deassertion SHALL have i_ready=1.

Verification (SIZE_ROW=8, PIX_PER_WORD=4, NUM_LINES=3, PIX_W=8)
REQ-035 Send rows 0..2 with pixel = 16*row+col, i_sof on the first word, o_ready=1 -> no o_valid until the cycle after the 6th transfer; then 2 windows, and window sc=0 row 0 = {0,0,1,2,3,4} (BORDER_MODE=0).
REQ-036 Same stimulus with BORDER_MODE=1 -> sc=0 row 2 = {32,32,33,34,35,36}; sc=1 row 2 = {35,36,37,38,39,39} with o_last=1.
REQ-037 Hold o_ready=0 for 5 cycles during SCAN -> o_valid stays 1, o_window/o_col unchanged, i_ready=0; 2 windows total after release.
REQ-038 Send row 3 -> windows use rows 1..3, o_row increments from 1 to 2 after the o_last transfer; then i_sof on the next word -> o_row=0 and no output until 3 new rows are loaded.
REQ-039 Assert reset during SCAN -> next cycle o_valid=0, i_ready=1; the following 2 rows produce no output.
REQ-040 Toggle i_valid randomly with a 50% duty cycle over a 4-row frame -> output windows are identical to the gap-free run.

Source files
------------

// File: rtl/sliding_window_buffer_if.sv
// Pixel-stream interface of the sliding window buffer: input word handshake
// plus the window output handshake and its side-band descriptors.
interface sliding_window_buffer_if #(
  parameter int SIZE_ROW     = 352,
  parameter int PIX_PER_WORD = 4,
  parameter int PIX_W        = 8,
  parameter int NUM_LINES    = 3
);
  localparam int WORDS = SIZE_ROW / PIX_PER_WORD;
  localparam int WIN_W = PIX_PER_WORD + 2;
  localparam int CW    = $clog2(WORDS);

  logic                               i_valid;
  logic                               i_ready;
  logic                               i_sof;
  logic [PIX_PER_WORD*PIX_W-1:0]      i_word;
  logic                               o_valid;
  logic                               o_ready;
  logic [NUM_LINES*WIN_W*PIX_W-1:0]   o_window;
  logic [CW-1:0]                      o_col;
  logic                               o_last;
  logic [15:0]                        o_row;

  modport slave (
    input  i_valid, i_sof, i_word, o_ready,
    output i_ready, o_valid, o_window, o_col, o_last, o_row
  );

  modport master (
    output i_valid, i_sof, i_word, o_ready,
    input  i_ready, o_valid, o_window, o_col, o_last, o_row
  );
endinterface

// File: rtl/sliding_window_buffer.sv
// Line buffer that collects NUM_LINES image rows and then scans them word by
// word, presenting a NUM_LINES x (PIX_PER_WORD+2) pixel window per word with
// one pixel of horizontal context on each side (zero or edge replicated).
module sliding_window_buffer #(
  parameter int SIZE_ROW     = 352,
  parameter int PIX_PER_WORD = 4,
  parameter int PIX_W        = 8,
  parameter int NUM_LINES    = 3,
  parameter int BORDER_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  sliding_window_buffer_if.slave  bus
);
  localparam int WORDS  = SIZE_ROW / PIX_PER_WORD;
  localparam int WIN_W  = PIX_PER_WORD + 2;
  localparam int CW     = $clog2(WORDS);
  localparam int WORD_W = PIX_PER_WORD * PIX_W;
  localparam int RW     = $clog2(NUM_LINES + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(WORDS - 1);
  localparam logic [RW-1:0] FULL     = RW'(NUM_LINES);

  typedef enum logic {ACCEPT = 1'b0, SCAN = 1'b1} state_e;

  logic [WORD_W-1:0] line_q  [NUM_LINES][WORDS];
  logic [WORD_W-1:0] stage_q [WORDS];

  state_e        state_q, state_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [CW-1:0] sc_q, sc_d;
  logic [RW-1:0] rows_q, rows_d;
  logic [15:0]   orow_q, orow_d;

  logic          in_fire, out_fire, row_done;
  logic [CW-1:0] wr_col, left_idx, right_idx;
  logic [RW-1:0] rows_base;
  logic [NUM_LINES*WIN_W*PIX_W-1:0] win;

  // A start-of-frame word always lands in column 0 and restarts the row count
  assign in_fire   = bus.i_valid && bus.i_ready;
  assign out_fire  = bus.o_valid && bus.o_ready;
  assign wr_col    = bus.i_sof ? '0 : wc_q;
  assign row_done  = in_fire && (wr_col == LAST_COL);
  assign rows_base = bus.i_sof ? '0 : rows_q;

  // Next values of the write column, scan column, loaded-row and output-row counters
  always_comb begin
    wc_d   = wc_q;
    rows_d = rows_q;
    sc_d   = sc_q;
    orow_d = orow_q;
    if (in_fire) begin
      wc_d   = row_done ? '0 : wr_col + CW'(1);
      rows_d = rows_base;
      if (row_done && rows_base != FULL) rows_d = rows_base + RW'(1);
      if (bus.i_sof) orow_d = '0;
    end
    if (out_fire) begin
      if (bus.o_last) begin
        sc_d   = '0;
        orow_d = orow_q + 16'd1;
      end else begin
        sc_d = sc_q + CW'(1);
      end
    end
  end

  // Scan starts once a completed row brings the buffer to NUM_LINES rows
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (row_done && rows_d == FULL) state_d = SCAN;
      SCAN:    if (out_fire && bus.o_last) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // Handshake outputs follow the state and are forced low while in reset
  always_comb begin
    bus.i_ready = 1'b0;
    bus.o_valid = 1'b0;
    if (!reset) begin
      bus.i_ready = (state_q == ACCEPT);
      bus.o_valid = (state_q == SCAN);
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCEPT;
      wc_q    <= '0;
      sc_q    <= '0;
      rows_q  <= '0;
      orow_q  <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      sc_q    <= sc_d;
      rows_q  <= rows_d;
      orow_q  <= orow_d;
    end
  end

  // Staging row fill; on the last word the line stack shifts up and takes the staged row
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_LINES; k++)
        for (int w = 0; w < WORDS; w++) line_q[k][w] <= '0;
      for (int w = 0; w < WORDS; w++) stage_q[w] <= '0;
    end else if (in_fire) begin
      stage_q[wr_col] <= bus.i_word;
      if (row_done) begin
        for (int k = 0; k < NUM_LINES - 1; k++)
          for (int w = 0; w < WORDS; w++) line_q[k][w] <= line_q[k+1][w];
        for (int w = 0; w < WORDS; w++)
          line_q[NUM_LINES-1][w] <= (CW'(w) == wr_col) ? bus.i_word : stage_q[w];
      end
    end
  end

  // Neighbouring word indices, clamped so the border columns never index out of range
  assign left_idx  = (sc_q == '0)       ? '0       : sc_q - CW'(1);
  assign right_idx = (sc_q == LAST_COL) ? LAST_COL : sc_q + CW'(1);

  for (genvar r = 0; r < NUM_LINES; r++) begin : g_row
    logic [PIX_W-1:0] left_px, right_px;

    assign left_px  = (sc_q == '0)
                      ? ((BORDER_MODE != 0) ? line_q[r][0][PIX_W-1:0] : '0)
                      : line_q[r][left_idx][WORD_W-1 -: PIX_W];
    assign right_px = (sc_q == LAST_COL)
                      ? ((BORDER_MODE != 0) ? line_q[r][WORDS-1][WORD_W-1 -: PIX_W] : '0)
                      : line_q[r][right_idx][PIX_W-1:0];

    assign win[(r*WIN_W)*PIX_W +: PIX_W]           = left_px;
    assign win[(r*WIN_W+1)*PIX_W +: WORD_W]        = line_q[r][sc_q];
    assign win[(r*WIN_W+WIN_W-1)*PIX_W +: PIX_W]   = right_px;
  end

  assign bus.o_window = win;
  assign bus.o_col    = sc_q;
  assign bus.o_last   = bus.o_valid && (sc_q == LAST_COL);
  assign bus.o_row    = orow_q;
endmodule

// File: tb/tb_sliding_window_buffer.sv
// Directed/random bench for sliding_window_buffer: two instances (zero-pad and
// edge-replicate borders) share one stimulus stream and are compared against a
// row-history reference model.
module tb_sliding_window_buffer;
  localparam int SIZE_ROW = 8;
  localparam int PPW      = 4;
  localparam int PIX_W    = 8;
  localparam int NL       = 3;
  localparam int WORDS    = SIZE_ROW / PPW;
  localparam int WIN_W    = PPW + 2;
  localparam int WINB     = NL * WIN_W * PIX_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sliding_window_buffer_if #(.SIZE_ROW(SIZE_ROW), .PIX_PER_WORD(PPW), .PIX_W(PIX_W),
                             .NUM_LINES(NL)) if0 ();
  sliding_window_buffer_if #(.SIZE_ROW(SIZE_ROW), .PIX_PER_WORD(PPW), .PIX_W(PIX_W),
                             .NUM_LINES(NL)) if1 ();

  sliding_window_buffer #(.SIZE_ROW(SIZE_ROW), .PIX_PER_WORD(PPW), .PIX_W(PIX_W),
                          .NUM_LINES(NL), .BORDER_MODE(0))
    dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  sliding_window_buffer #(.SIZE_ROW(SIZE_ROW), .PIX_PER_WORD(PPW), .PIX_W(PIX_W),
                          .NUM_LINES(NL), .BORDER_MODE(1))
    dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  assign if1.i_valid = if0.i_valid;
  assign if1.i_sof   = if0.i_sof;
  assign if1.i_word  = if0.i_word;
  assign if1.o_ready = if0.o_ready;

  int tests = 0;
  int fails = 0;

  // reference model: completed rows (oldest first), partial row, counters
  logic [SIZE_ROW*PIX_W-1:0] hist[$];
  logic [SIZE_ROW*PIX_W-1:0] part;
  int  m_wc, m_loaded, m_orow;
  bit  exp_scan;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WINB-1:0] exp_win(input int sc, input int mode);
    logic [WINB-1:0] w;
    logic [SIZE_ROW*PIX_W-1:0] rw;
    logic [PIX_W-1:0] p;
    int col;
    w = '0;
    for (int r = 0; r < NL; r++) begin
      rw = hist[r];
      for (int c = 0; c < WIN_W; c++) begin
        col = sc * PPW - 1 + c;
        if (col < 0)              p = (mode != 0) ? rw[PIX_W-1:0] : '0;
        else if (col >= SIZE_ROW) p = (mode != 0) ? rw[SIZE_ROW*PIX_W-1 -: PIX_W] : '0;
        else                      p = rw[col*PIX_W +: PIX_W];
        w[(r*WIN_W+c)*PIX_W +: PIX_W] = p;
      end
    end
    return w;
  endfunction

  task automatic model_reset;
    hist.delete();
    part = '0;
    m_wc = 0; m_loaded = 0; m_orow = 0;
  endtask

  task automatic model_word(input logic [PPW*PIX_W-1:0] w, input bit sof);
    if (sof) begin m_wc = 0; m_loaded = 0; m_orow = 0; end
    part[m_wc*PPW*PIX_W +: PPW*PIX_W] = w;
    m_wc++;
    exp_scan = 1'b0;
    if (m_wc == WORDS) begin
      m_wc = 0;
      hist.push_back(part);
      if (hist.size() > NL) void'(hist.pop_front());
      if (m_loaded < NL) m_loaded++;
      exp_scan = (m_loaded == NL);
    end
  endtask

  task automatic send_word(input logic [PPW*PIX_W-1:0] w, input bit sof, input bit gaps);
    int g, n;
    g = 0;
    while (gaps && g < 8 && $urandom_range(1, 0) == 1) begin
      if0.i_valid = 1'b0;
      if0.i_sof   = 1'($urandom_range(1, 0));
      if0.i_word  = $urandom;
      tick;
      check("idle_o_valid", if0.o_valid, 1'b0);
      g++;
    end
    if0.i_valid = 1'b1;
    if0.i_sof   = sof;
    if0.i_word  = w;
    n = 0;
    while (!if0.i_ready && n < 50) begin tick; n++; end
    check("i_ready_wait", if0.i_ready, 1'b1);
    tick;
    if0.i_valid = 1'b0;
    if0.i_sof   = 1'b0;
    model_word(w, sof);
    check("latency_o_valid_b0", if0.o_valid, exp_scan);
    check("latency_o_valid_b1", if1.o_valid, exp_scan);
    if (sof) check("sof_o_row", if0.o_row, 16'd0);
  endtask

  task automatic scan_row(input int hold, input bit dir);
    int n;
    for (int sc = 0; sc < WORDS; sc++) begin
      n = 0;
      while (!if0.o_valid && n < 20) begin tick; n++; end
      check("scan_o_valid", if0.o_valid, 1'b1);
      check("scan_o_col", if0.o_col, sc);
      check("scan_o_last", if0.o_last, (sc == WORDS - 1));
      check("scan_i_ready", if0.i_ready, 1'b0);
      check("window_zero_pad", if0.o_window, exp_win(sc, 0));
      check("window_replicate", if1.o_window, exp_win(sc, 1));
      if (dir && sc == 0) begin
        check("zero_pad_row0_sc0", if0.o_window[47:0], 48'h040302010000);
        check("replicate_row2_sc0", if1.o_window[143:96], 48'h242322212020);
      end
      if (dir && sc == 1)
        check("replicate_row2_sc1", if1.o_window[143:96], 48'h272726252423);
      if (hold > 0 && sc == 0) begin
        if0.o_ready = 1'b0;
        if0.i_valid = 1'b1;
        if0.i_sof   = 1'b1;
        for (int h = 0; h < hold; h++) begin
          tick;
          check("hold_o_valid", if0.o_valid, 1'b1);
          check("hold_o_col", if0.o_col, 0);
          check("hold_window", if0.o_window, exp_win(0, 0));
          check("hold_i_ready", if0.i_ready, 1'b0);
        end
        if0.i_valid = 1'b0;
        if0.i_sof   = 1'b0;
        if0.o_ready = 1'b1;
      end
      tick;
    end
    m_orow++;
    check("o_row_after_last", if0.o_row, 16'(m_orow));
    check("back_to_accept", if0.i_ready, 1'b1);
    check("no_valid_after_scan", if0.o_valid, 1'b0);
  endtask

  task automatic send_row(input logic [SIZE_ROW*PIX_W-1:0] row, input bit sof,
                          input bit gaps, input bit do_scan, input int hold, input bit dir);
    for (int w = 0; w < WORDS; w++)
      send_word(row[w*PPW*PIX_W +: PPW*PIX_W], sof && (w == 0), gaps);
    if (exp_scan && do_scan) scan_row(hold, dir);
  endtask

  function automatic logic [SIZE_ROW*PIX_W-1:0] ramp_row(input int r);
    logic [SIZE_ROW*PIX_W-1:0] v;
    for (int c = 0; c < SIZE_ROW; c++) v[c*PIX_W +: PIX_W] = 8'(16 * r + c);
    return v;
  endfunction

  function automatic logic [SIZE_ROW*PIX_W-1:0] rand_row();
    logic [SIZE_ROW*PIX_W-1:0] v;
    for (int c = 0; c < SIZE_ROW; c++) v[c*PIX_W +: PIX_W] = 8'($urandom);
    return v;
  endfunction

  initial begin
    reset       = 1'b1;
    if0.i_valid = 1'b0;
    if0.i_sof   = 1'b0;
    if0.i_word  = '0;
    if0.o_ready = 1'b1;
    model_reset();
    exp_scan = 1'b0;
    repeat (3) tick;
    check("reset_i_ready", if0.i_ready, 1'b0);
    check("reset_o_valid", if0.o_valid, 1'b0);
    reset = 1'b0;
    tick;
    check("post_reset_i_ready", if0.i_ready, 1'b1);
    check("post_reset_o_valid", if0.o_valid, 1'b0);
    check("post_reset_o_row", if0.o_row, 16'd0);
    check("post_reset_o_col", if0.o_col, 0);

    // ramp frame: rows 0..2, then row 3 with a 5-cycle output stall
    for (int r = 0; r < 3; r++) send_row(ramp_row(r), (r == 0), 1'b0, 1'b1, 0, (r == 2));
    send_row(ramp_row(3), 1'b0, 1'b0, 1'b1, 5, 1'b0);
    check("o_row_two", if0.o_row, 16'd2);

    // new frame of 4 random rows with random input gaps
    for (int r = 0; r < 4; r++) send_row(rand_row(), (r == 0), 1'b1, 1'b1, 0, 1'b0);

    // partial row abandoned by a fresh start of frame
    send_word($urandom, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) send_row(rand_row(), (r == 0), 1'b1, 1'b1, 0, 1'b0);

    // reset while a window row is being presented
    send_row(rand_row(), 1'b0, 1'b0, 1'b0, 0, 1'b0);
    check("pre_reset_scan", if0.o_valid, 1'b1);
    reset = 1'b1;
    tick;
    check("scan_reset_o_valid", if0.o_valid, 1'b0);
    check("scan_reset_i_ready", if0.i_ready, 1'b0);
    model_reset();
    exp_scan = 1'b0;
    reset = 1'b0;
    tick;
    check("scan_release_i_ready", if0.i_ready, 1'b1);
    check("scan_release_o_valid", if0.o_valid, 1'b0);
    check("scan_release_o_row", if0.o_row, 16'd0);
    for (int r = 0; r < 3; r++) send_row(rand_row(), 1'b0, 1'b0, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
